// File: rtl/string_composer_pkg.sv
// Shared text definitions: ASCII control codes, character kinds and composer FSM states.
// Imported by the string composer and the text renderer.
package string_composer_pkg;

  localparam logic [7:0] AsciiBs     = 8'h08;
  localparam logic [7:0] AsciiCr     = 8'h0D;
  localparam logic [7:0] AsciiEsc    = 8'h1B;
  localparam logic [7:0] AsciiSpace  = 8'h20;
  localparam logic [7:0] AsciiUpperA = 8'h41;
  localparam logic [7:0] AsciiUpperZ = 8'h5A;
  localparam logic [7:0] AsciiLowerA = 8'h61;
  localparam logic [7:0] AsciiLowerZ = 8'h7A;
  localparam logic [7:0] CaseOffset  = 8'h20;

  typedef enum logic [1:0] {
    StEdit    = 2'd0,
    StPending = 2'd1,
    StPublish = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    KindIgnore    = 3'd0,
    KindPrint     = 3'd1,
    KindBackspace = 3'd2,
    KindEnter     = 3'd3,
    KindClear     = 3'd4
  } kind_e;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= AsciiUpperA) && (c <= AsciiUpperZ);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= AsciiLowerA) && (c <= AsciiLowerZ);
  endfunction

endpackage

// File: rtl/string_composer_if.sv
// Keyboard-decoder character stream: valid/ready handshake carrying one ASCII code per transfer.
interface string_composer_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;

  modport master (
    output char_in,
    output char_valid,
    input  char_ready
  );

  modport slave (
    input  char_in,
    input  char_valid,
    output char_ready
  );
endinterface

// File: rtl/ascii_classify.sv
// Combinational classifier: sorts an ASCII code into a character kind and folds
// lower-case letters to upper case.
module ascii_classify
  import string_composer_pkg::*;
(
  input  logic [7:0] i_char_in,
  output kind_e      o_kind,
  output logic [7:0] o_folded
);

  always_comb begin
    o_kind   = KindIgnore;
    o_folded = i_char_in;
    if (is_upper(i_char_in) || (i_char_in == AsciiSpace)) begin
      o_kind = KindPrint;
    end else if (is_lower(i_char_in)) begin
      o_kind   = KindPrint;
      o_folded = i_char_in - CaseOffset;
    end else begin
      case (i_char_in)
        AsciiBs:  o_kind = KindBackspace;
        AsciiCr:  o_kind = KindEnter;
        AsciiEsc: o_kind = KindClear;
        default:  o_kind = KindIgnore;
      endcase
    end
  end

endmodule

// File: rtl/string_composer.sv
// Line editor for keyboard text: edits a private buffer, then on enter commits it to the
// display-facing string at the next frame boundary (vsync rising edge).
module string_composer
  import string_composer_pkg::*;
#(
  parameter int unsigned STRING_LENGTH = 9
) (
  input  logic                         clk,
  input  logic                         reset_n,
  string_composer_if.slave             char_if,
  input  logic                         i_vsync,
  output logic [STRING_LENGTH*8-1:0]   o_string,
  output logic [5:0]                   o_numchar,
  output logic                         o_ready,
  output logic                         o_full,
  output logic                         o_overflow
);

  localparam logic [5:0] LenCount = 6'(STRING_LENGTH);

  state_e                       r_state, w_state_next;
  logic                         r_vsync;
  logic                         w_vsync_rise;
  logic [5:0]                   r_count, w_count_next;
  logic [7:0]                   r_buf [STRING_LENGTH];
  logic [7:0]                   w_buf_next [STRING_LENGTH];
  logic [STRING_LENGTH*8-1:0]   w_buf_flat;
  logic [STRING_LENGTH*8-1:0]   r_string;
  logic [5:0]                   r_numchar;
  logic                         r_overflow, w_overflow_next;
  logic                         w_accept;
  logic                         w_publish;
  kind_e                        w_kind;
  logic [7:0]                   w_folded;

  ascii_classify u_classify (
    .i_char_in (char_if.char_in),
    .o_kind    (w_kind),
    .o_folded  (w_folded)
  );

  assign char_if.char_ready = (r_state == StEdit);
  assign w_accept           = char_if.char_valid & char_if.char_ready;
  assign w_vsync_rise       = i_vsync & ~r_vsync;

  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_buf_next      = r_buf;
    w_overflow_next = 1'b0;
    w_publish       = 1'b0;
    unique case (r_state)
      StEdit: begin
        if (w_accept) begin
          case (w_kind)
            KindPrint: begin
              if (r_count < LenCount) begin
                for (int unsigned i = 0; i < STRING_LENGTH; i++) begin
                  if (r_count == 6'(i)) w_buf_next[i] = w_folded;
                end
                w_count_next = r_count + 6'd1;
              end else begin
                w_overflow_next = 1'b1;
              end
            end
            KindBackspace: begin
              // Positions at or beyond the count are kept blank so a commit needs no masking.
              if (r_count != 6'd0) begin
                w_count_next = r_count - 6'd1;
                for (int unsigned i = 0; i < STRING_LENGTH; i++) begin
                  if (w_count_next == 6'(i)) w_buf_next[i] = AsciiSpace;
                end
              end
            end
            KindEnter: w_state_next = StPending;
            KindClear: begin
              w_count_next = 6'd0;
              for (int unsigned i = 0; i < STRING_LENGTH; i++) w_buf_next[i] = AsciiSpace;
            end
            default: ;
          endcase
        end
      end
      StPending: begin
        if (w_vsync_rise) begin
          w_state_next = StPublish;
          w_publish    = 1'b1;
        end
      end
      StPublish: w_state_next = StEdit;
      default:   w_state_next = StEdit;
    endcase
  end

  // Character 0 lands in the most significant byte.
  always_comb begin
    w_buf_flat = '0;
    for (int unsigned i = 0; i < STRING_LENGTH; i++) begin
      w_buf_flat[(STRING_LENGTH-1-i)*8 +: 8] = r_buf[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StEdit;
      r_vsync    <= 1'b0;
      r_count    <= 6'd0;
      r_overflow <= 1'b0;
      for (int unsigned i = 0; i < STRING_LENGTH; i++) r_buf[i] <= AsciiSpace;
    end else begin
      r_state    <= w_state_next;
      r_vsync    <= i_vsync;
      r_count    <= w_count_next;
      r_overflow <= w_overflow_next;
      r_buf      <= w_buf_next;
    end
  end

  // Commit is latched on entry to publish so the update and ready appear together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_string  <= {STRING_LENGTH{AsciiSpace}};
      r_numchar <= 6'd0;
    end else if (w_publish) begin
      r_string  <= w_buf_flat;
      r_numchar <= r_count;
    end
  end

  assign o_string   = r_string;
  assign o_numchar  = r_numchar;
  assign o_ready    = (r_state == StPublish);
  assign o_full     = (r_count == LenCount);
  assign o_overflow = r_overflow;

endmodule

// File: doc/string_composer.md
STRING_COMPOSER -- requirements
Module: string_composer

Interface
REQ-001 SHALL have parameter STRING_LENGTH, default 9, meaning the character capacity of the string; legal range is 1..63.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock (pixel clock domain, 65 MHz); all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port char_in, input, 8 bits: the ASCII code offered by the keyboard decoder.
REQ-005 SHALL have port char_valid, input, 1 bit: char_in is valid this cycle.
REQ-006 SHALL have port char_ready, output, 1 bit: the block accepts char_in this cycle; a transfer occurs when char_valid and char_ready are both high.
REQ-007 SHALL have port vsync, input, 1 bit: frame sync, same clock domain; the rising edge marks the frame boundary.
REQ-008 SHALL have port string, output, STRING_LENGTH*8 bits: the committed text, character 0 in the MSBs.
REQ-009 SHALL have port numchar, output, 6 bits: the committed character count.
REQ-010 SHALL have port ready, output, 1 bit: one-cycle pulse when string and numchar are updated.
REQ-011 SHALL have port full, output, 1 bit: high while the edit count equals STRING_LENGTH.
REQ-012 SHALL have port overflow, output, 1 bit: one-cycle pulse when a printable character is dropped because the buffer is full.

Function
REQ-013 SHALL keep an edit buffer (STRING_LENGTH bytes) and an edit count, separate from the committed string and numchar outputs.
REQ-014 SHALL classify each accepted char_in as follows:
- 0x41-0x5A and 0x20: printable.
- 0x61-0x7A: printable after subtracting 0x20.
- 0x08: backspace.
- 0x0D: enter.
- 0x1B: clear.
- Any other code: consumed and ignored.
REQ-015 SHALL, on a printable character with count < STRING_LENGTH, write it to edit position count and increment count in the same cycle.
REQ-016 SHALL, on a printable character with count == STRING_LENGTH, leave the buffer and count unchanged and pulse overflow the following cycle.
REQ-017 SHALL, on backspace with count > 0, decrement count and write 0x20 to the vacated position; with count == 0 it does nothing.
REQ-018 SHALL, on clear, set count to 0 and fill all edit positions with 0x20; the committed outputs are untouched.
REQ-019 SHALL implement the FSM with states and transitions:
- EDIT -> PENDING on enter.
- PENDING -> PUBLISH on a vsync rising edge, detected by comparing vsync with its registered value.
- PUBLISH -> EDIT after exactly one cycle.
REQ-020 SHALL drive char_ready = 1 in EDIT and 0 in PENDING and PUBLISH.
REQ-021 SHALL, in PUBLISH:
- copy the edit buffer to string;
- copy count to numchar;
- assert ready that cycle only, so the update is visible the cycle after the vsync edge is detected;
- leave the edit buffer intact for further editing.
REQ-022 SHALL always hold unused string positions (index >= numchar) at 0x20.
REQ-023 SHALL ignore a vsync edge in EDIT; a vsync edge coinciding with enter does not publish until the next edge.
REQ-024 SHALL apply enter with count == 0 normally, publishing numchar = 0.

Reset
REQ-025 SHALL, while reset_n is low, asynchronously force:
- FSM to EDIT and count to 0;
- edit buffer and string to all 0x20;
- numchar to 0;
- ready, overflow and full to 0;
- the vsync history register to 0.
REQ-026 SHALL, when reset is asserted mid-PENDING, discard the pending commit.

Structure
REQ-027 SHALL take the ASCII constants (0x08, 0x0D, 0x1B, 0x20) and the FSM state encodings from a shared text package also used by the text renderer.
REQ-028 SHALL implement character classification and case folding as one combinational sub-module, ascii_classify (input char_in; outputs kind and folded code).

Verification
REQ-029 Bench SHALL cover: reset, then send "h","i",enter, then a vsync edge -> ready pulses once, string = 0x48,0x49 then 0x20 x7, numchar = 2.
REQ-030 Bench SHALL cover: 10 printable characters with STRING_LENGTH = 9 -> full = 1 after the 9th, a single overflow pulse on the 10th, count stays 9.
REQ-031 Bench SHALL cover: "AB",backspace,backspace,backspace,enter, then vsync -> numchar = 0, string all 0x20, no error.
REQ-032 Bench SHALL cover: enter, then char_valid held with "Z" before vsync -> char_ready = 0 until PUBLISH completes; "Z" is accepted in EDIT afterward and is not in the published string.
REQ-033 Bench SHALL cover: enter, then reset_n pulsed low before vsync -> no ready on later vsync edges, outputs remain at reset values.
REQ-034 Bench SHALL cover: "AB", enter, publish, then clear -> committed string still "AB", edit count 0.
